genius_round_ctrl: RTL and testbench
====================================

GENIUS_ROUND_CTRL -- requirements
Module: genius_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the sequence length that wins the game (range 2..32).
REQ-002 SHALL have parameter SHOW_TICKS, default 25000000, meaning the number of CLK cycles each color lamp stays lit during playback.
REQ-003 SHALL have parameter GAP_TICKS, default 12500000, meaning the number of dark CLK cycles after each lamp.
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 250000000, meaning the maximum number of CLK cycles allowed between player presses.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock domain.
REQ-006 SHALL have port RST, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have port START, input, 1 bit, a new-game request, sampled every cycle.
REQ-008 SHALL have port BTN, input, 4 bits, active-low one-cycle press pulses from the button synchronizer; bit i is color i.
REQ-009 SHALL have port LED, output, 4 bits, active-high color lamps.
REQ-010 SHALL have port LEVEL, output, 6 bits, the current sequence length.
REQ-011 SHALL have port WIN, output, 1 bit, high while in state WIN.
REQ-012 SHALL have port LOSE, output, 1 bit, high while in state LOSE.

Function
REQ-013 SHALL implement states IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN and LOSE.
REQ-014 SHALL keep a free-running 16-bit maximal-length Galois LFSR: seed 16'hACE1, taps 16'hB400, advancing every cycle in every state; color = lfsr[1:0].
REQ-015 SHALL, in IDLE with START=1, clear LEVEL to 0 and go to ADD on the next cycle; SHALL ignore START in all other states except WIN and LOSE.
REQ-016 SHALL, in ADD, write the current color to mem[LEVEL], increment LEVEL, reset the playback index to 0 and go to SHOW_ON; ADD lasts exactly 1 cycle.
REQ-017 SHALL, in SHOW_ON, drive LED one-hot for mem[index] for exactly SHOW_TICKS cycles, then go to SHOW_OFF.
REQ-018 SHALL, in SHOW_OFF, drive LED=0 for exactly GAP_TICKS cycles, then increment index and go to SHOW_ON if index<LEVEL; otherwise clear index and the timeout counter and go to WAIT_IN.
REQ-019 SHALL ignore BTN in every state except WAIT_IN.
REQ-020 SHALL, in WAIT_IN, detect a press as BTN != 4'b1111 and treat exactly one low bit equal to mem[index] as correct; more than one low bit or a wrong color SHALL go to LOSE on the next cycle.
REQ-021 SHALL, in WAIT_IN, echo the pressed color on LED for that same cycle only, and drive LED=0 otherwise.
REQ-022 SHALL, on a correct press with index<LEVEL-1, increment index and clear the timeout counter.
REQ-023 SHALL, on a correct press with index=LEVEL-1, go to WIN if LEVEL=MAX_LEN, else go to ADD.
REQ-024 SHALL go from WAIT_IN to LOSE when the timeout counter reaches TIMEOUT_TICKS-1 with no press; a press in that same cycle SHALL take priority.
REQ-025 SHALL drive LED=4'b1111 in WIN and LED=4'b0000 in LOSE; START=1 in either state SHALL behave as in IDLE (clear LEVEL, go to ADD).
REQ-026 SHALL register LED, WIN and LOSE so that they change on the CLK edge on which the state changes.

Reset
REQ-027 SHALL, while RST=1 at a CLK edge, force IDLE, LEVEL=0, index=0, all counters=0, LED=0, WIN=0, LOSE=0 and the LFSR to its seed, taking priority over every other input in every state including mid-playback.
REQ-028 SHALL NOT reset the sequence memory contents; its contents are don't-care until rewritten by ADD.

Structure
REQ-029 SHALL take the state enum, the LFSR seed/tap constants and the 2-bit color encoding from shared package genius_pkg.
REQ-030 SHALL place the LFSR in sub-module genius_lfsr (ports CLK, RST, Q[15:0]); the sequence memory SHALL be a 32x2 register array inside genius_round_ctrl.

Verification
REQ-031 Bench SHALL use MAX_LEN=3, SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20 for all scenarios.
REQ-032 START pulse in IDLE -> ADD for 1 cycle, then LED one-hot for 4 cycles, 0 for 2 cycles, WAIT_IN with LEVEL=1.
REQ-033 Replay correct colors at each level -> LEVEL steps 1,2,3 -> WIN=1, LED=4'b1111 one cycle after the last correct press.
REQ-034 At LEVEL=2, press a wrong color (or BTN=4'b1100) -> LOSE=1 and LED=0 on the next cycle; a subsequent START -> LEVEL=1.
REQ-035 Idle for 20 cycles in WAIT_IN -> LOSE; a correct press on cycle 19 -> no LOSE.
REQ-036 Presses during SHOW_ON/SHOW_OFF -> no effect; RST asserted mid-SHOW_ON -> IDLE, LED=0, LEVEL=0 on the next edge.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and constants for the genius memory game: round FSM states,
// LFSR seed/taps and the 2-bit color encoding with its one-hot lamp decode.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [1:0] color_t;

  function automatic logic [3:0] color_onehot(color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Galois LFSR used as the color source; it advances every
// cycle regardless of game state so colors depend on player timing.
module genius_lfsr
  import genius_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST)
      Q <= LFSR_SEED;
    else if (Q[0])
      Q <= (Q >> 1) ^ LFSR_TAPS;
    else
      Q <= Q >> 1;
  end

endmodule

// File: rtl/genius_round_ctrl.sv
// Round controller for the genius memory game: grows a random color sequence,
// plays it back on the lamps and checks the player's replay.
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int MAX_LEN       = 16,
  parameter int SHOW_TICKS    = 25000000,
  parameter int GAP_TICKS     = 12500000,
  parameter int TIMEOUT_TICKS = 250000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] BTN,
  output logic [3:0] LED,
  output logic [5:0] LEVEL,
  output logic       WIN,
  output logic       LOSE
);

  localparam logic [31:0] SHOW_LAST    = 32'(SHOW_TICKS - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_TICKS - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_TICKS - 1);
  localparam logic [5:0]  LEN_WIN      = 6'(MAX_LEN);

  logic [15:0] lfsr_q;
  color_t      color;
  logic        unused_lfsr;

  genius_lfsr u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .Q   (lfsr_q)
  );

  assign color       = lfsr_q[1:0];
  assign unused_lfsr = ^lfsr_q[15:2];

  state_t      state, state_d;
  logic [5:0]  level, level_d;
  logic [4:0]  index, index_d;
  logic [31:0] cnt, cnt_d;
  logic [3:0]  led_d;
  logic        mem_we;
  color_t      mem [32];

  logic [3:0]  pressed;
  logic        press, single_press, correct, last_press, more_show;
  logic [4:0]  next_index;

  assign pressed      = ~BTN;
  assign press        = |pressed;
  assign single_press = press && ((pressed & (pressed - 4'd1)) == 4'd0);
  assign correct      = single_press && (pressed == color_onehot(mem[index]));
  assign last_press   = ({1'b0, index} == (level - 6'd1));
  assign next_index   = index + 5'd1;
  assign more_show    = ({1'b0, next_index} < level);
  assign LEVEL        = level;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      level <= '0;
      index <= '0;
      cnt   <= '0;
      LED   <= '0;
      WIN   <= 1'b0;
      LOSE  <= 1'b0;
    end else begin
      state <= state_d;
      level <= level_d;
      index <= index_d;
      cnt   <= cnt_d;
      LED   <= led_d;
      WIN   <= (state_d == ST_WIN);
      LOSE  <= (state_d == ST_LOSE);
    end
  end

  // Sequence memory is deliberately not reset; ADD rewrites each slot before use.
  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[level[4:0]] <= color;
  end

  // LED is computed for the state being entered so the lamp flop switches on
  // the same edge as the state register.
  always_comb begin
    state_d = state;
    level_d = level;
    index_d = index;
    cnt_d   = cnt;
    led_d   = LED;
    mem_we  = 1'b0;

    case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (START) begin
          level_d = '0;
          state_d = ST_ADD;
          led_d   = 4'b0000;
        end
      end

      ST_ADD: begin
        mem_we  = 1'b1;
        level_d = level + 6'd1;
        index_d = '0;
        cnt_d   = '0;
        state_d = ST_SHOW_ON;
        // Slot 0 is still being written on the very first round.
        led_d   = color_onehot((level == 6'd0) ? color : mem[0]);
      end

      ST_SHOW_ON: begin
        if (cnt == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHOW_OFF;
          led_d   = 4'b0000;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end

      ST_SHOW_OFF: begin
        if (cnt == GAP_LAST) begin
          cnt_d = '0;
          if (more_show) begin
            index_d = next_index;
            state_d = ST_SHOW_ON;
            led_d   = color_onehot(mem[next_index]);
          end else begin
            index_d = '0;
            state_d = ST_WAIT_IN;
            led_d   = 4'b0000;
          end
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end

      ST_WAIT_IN: begin
        led_d = 4'b0000;
        if (press) begin
          if (!correct) begin
            state_d = ST_LOSE;
          end else if (!last_press) begin
            index_d = next_index;
            cnt_d   = '0;
            led_d   = pressed;
          end else if (level == LEN_WIN) begin
            cnt_d   = '0;
            state_d = ST_WIN;
            led_d   = 4'b1111;
          end else begin
            cnt_d   = '0;
            state_d = ST_ADD;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_d = ST_LOSE;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = 4'b0000;
      end
    endcase
  end

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Self-checking bench for genius_round_ctrl: table of whole-game scenarios with
// randomized timing/noise, plus hand sequences for reset and hold corner cases.
module tb_genius_round_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [3:0] BTN = 4'b1111;
  logic [3:0] LED;
  logic [5:0] LEVEL;
  logic       WIN;
  logic       LOSE;

  int total = 0;
  int bad   = 0;

  genius_round_ctrl #(
    .MAX_LEN       (3),
    .SHOW_TICKS    (4),
    .GAP_TICKS     (2),
    .TIMEOUT_TICKS (20)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .BTN   (BTN),
    .LED   (LED),
    .LEVEL (LEVEL),
    .WIN   (WIN),
    .LOSE  (LOSE)
  );

  always #5 CLK = ~CLK;

  // Reference color source: the LFSR rule applied once per clock, reseeded on reset.
  logic [15:0] m_lfsr = 16'hACE1;
  always @(posedge CLK) begin
    if (RST)
      m_lfsr <= 16'hACE1;
    else
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  logic [1:0] seq [$];

  typedef struct {
    int   fail_level;
    int   fail_kind;
    logic slow;
    logic noise;
    logic exp_win;
    logic exp_lose;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic applyStimulus(input logic rst_v, input logic start_v, input logic [3:0] btn_v);
    RST   = rst_v;
    START = start_v;
    BTN   = btn_v;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_led,
                             input logic [5:0] exp_level, input logic exp_win,
                             input logic exp_lose);
    total++;
    if (LED !== exp_led || LEVEL !== exp_level || WIN !== exp_win || LOSE !== exp_lose) begin
      bad++;
      $display("[TB] FAIL %s: got led=%b level=%0d win=%b lose=%b, want led=%b level=%0d win=%b lose=%b",
               name, LED, LEVEL, WIN, LOSE, exp_led, exp_level, exp_win, exp_lose);
    end
  endtask

  // From IDLE/WIN/LOSE: pulse START and land in the ADD cycle.
  task automatic startGame();
    seq.delete();
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("add_after_start", 4'b0000, 6'd0, 1'b0, 1'b0);
  endtask

  // Called during an ADD cycle: records the color drawn now, moves to playback.
  task automatic runAdd();
    seq.push_back(m_lfsr[1:0]);
    applyStimulus(1'b0, 1'b0, 4'b1111);
  endtask

  task automatic playback(input logic noise);
    int n;
    n = seq.size();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("show_on", oh(seq[i]), 6'(n), 1'b0, 1'b0);
        if (noise) applyStimulus(1'b0, 1'($urandom), 4'($urandom));
        else       applyStimulus(1'b0, 1'b0, 4'b1111);
      end
      for (int k = 0; k < 2; k++) begin
        checkOutput("show_off", 4'b0000, 6'(n), 1'b0, 1'b0);
        if (noise) applyStimulus(1'b0, 1'($urandom), 4'($urandom));
        else       applyStimulus(1'b0, 1'b0, 4'b1111);
      end
    end
    checkOutput("wait_in_entry", 4'b0000, 6'(n), 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input int d, input int lvl);
    for (int k = 0; k < d; k++) begin
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput("wait_idle", 4'b0000, 6'(lvl), 1'b0, 1'b0);
    end
  endtask

  task automatic playGame(input vec_t v, output int end_level);
    int  fail_press;
    int  d;
    int  a, b;
    logic [3:0] btn_v;
    logic ended;
    ended = 1'b0;
    end_level = 3;
    startGame();
    for (int lvl = 1; lvl <= 3 && !ended; lvl++) begin
      runAdd();
      playback(v.noise);
      fail_press = (v.fail_level == lvl) ? int'($urandom_range(0, lvl - 1)) : -1;
      for (int j = 0; j < lvl && !ended; j++) begin
        d = v.slow ? 19 : int'($urandom_range(0, 19));
        if (j == fail_press && v.fail_kind == 2) begin
          idleCycles(19, lvl);
          applyStimulus(1'b0, 1'b0, 4'b1111);
          end_level = lvl;
          ended = 1'b1;
        end else begin
          idleCycles(d, lvl);
          if (j == fail_press) begin
            if (v.fail_kind == 0) begin
              btn_v = ~oh(2'(seq[j] + 2'($urandom_range(1, 3))));
            end else begin
              a = int'($urandom_range(0, 3));
              b = (a + int'($urandom_range(1, 3))) % 4;
              btn_v = ($urandom_range(0, 3) == 0) ? 4'b0000 : ~(oh(2'(a)) | oh(2'(b)));
            end
            applyStimulus(1'b0, 1'b0, btn_v);
            end_level = lvl;
            ended = 1'b1;
          end else begin
            applyStimulus(1'b0, 1'b0, ~oh(seq[j]));
            if (j < lvl - 1)
              checkOutput("press_echo", oh(seq[j]), 6'(lvl), 1'b0, 1'b0);
            else if (lvl < 3)
              checkOutput("round_done_add", 4'b0000, 6'(lvl), 1'b0, 1'b0);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int end_level;

    vecs[0] = '{fail_level: 0, fail_kind: 0, slow: 1'b0, noise: 1'b1, exp_win: 1'b1, exp_lose: 1'b0};
    vecs[1] = '{fail_level: 2, fail_kind: 0, slow: 1'b0, noise: 1'b0, exp_win: 1'b0, exp_lose: 1'b1};
    vecs[2] = '{fail_level: 2, fail_kind: 1, slow: 1'b0, noise: 1'b1, exp_win: 1'b0, exp_lose: 1'b1};
    vecs[3] = '{fail_level: 1, fail_kind: 2, slow: 1'b0, noise: 1'b0, exp_win: 1'b0, exp_lose: 1'b1};
    vecs[4] = '{fail_level: 3, fail_kind: 0, slow: 1'b0, noise: 1'b1, exp_win: 1'b0, exp_lose: 1'b1};
    vecs[5] = '{fail_level: 3, fail_kind: 2, slow: 1'b1, noise: 1'b0, exp_win: 1'b0, exp_lose: 1'b1};
    vecs[6] = '{fail_level: 0, fail_kind: 0, slow: 1'b1, noise: 1'b1, exp_win: 1'b1, exp_lose: 1'b0};

    $display("[TB] reset and idle checks");
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("reset_state", 4'b0000, 6'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 4'($urandom));
      checkOutput("idle_ignores_btn", 4'b0000, 6'd0, 1'b0, 1'b0);
    end

    $display("[TB] reset during playback");
    startGame();
    runAdd();
    checkOutput("first_show", oh(seq[0]), 6'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b1111);
    checkOutput("first_show_hold", oh(seq[0]), 6'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1111);
    checkOutput("rst_mid_show", 4'b0000, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b1111);
    checkOutput("idle_after_rst", 4'b0000, 6'd0, 1'b0, 1'b0);

    $display("[TB] scenario table");
    for (int i = 0; i < 7; i++) begin
      playGame(vecs[i], end_level);
      checkOutput($sformatf("game_outcome_%0d", i), vecs[i].exp_win ? 4'b1111 : 4'b0000,
                  6'(end_level), vecs[i].exp_win, vecs[i].exp_lose);
    end

    $display("[TB] win hold and restart");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 4'($urandom));
      checkOutput("win_hold", 4'b1111, 6'd3, 1'b1, 1'b0);
    end
    startGame();
    runAdd();
    checkOutput("restart_level1", oh(seq[0]), 6'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
